load_store_unit: RTL and testbench

Sits between the core's execute stage and the word-wide memory block, converting one RV32 load/store request at a time into a single bus transaction. Generates byte strobes and lane-replicated store data, then extracts and sign/zero-extends load data. Traps misaligned and undefined accesses without touching the bus. Holds at most one request in flight and returns one registered response pulse per accepted request.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core package: RV32 load/store funct3 codes, trap causes, LSU state type,
// and the request legality check used at accept time.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_FAULT = 2'd2
  } lsu_state_e;

  // Trap cause for a request, CAUSE_NONE when it may go to the bus.
  // Undefined encodings take precedence over alignment.
  function automatic logic [3:0] lsu_check(input logic       write,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
    logic undef;
    logic misal;
    undef = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (write && f3[2]);
    misal = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
            ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (undef)      return write ? CAUSE_ST_ACCESS   : CAUSE_LD_ACCESS;
    else if (misal) return write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else            return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication and strobes, load
// shift and sign/zero extension. Also used by the core's forwarding path.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  // Store: replicate the right-aligned datum into every lane, strobe its slot
  always_comb begin
    o_wdata = i_wdata;
    o_wstrb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_addr_lo;
      end
      2'b01: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = 4'b0011 << i_addr_lo;
      end
      default: begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  // Load: bring the addressed bytes to bit 0, then extend
  always_comb begin
    o_rdata = i_rdata;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shift[7]}},  w_shift[7:0]};
      F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
      F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request in flight, one word-bus transaction per
// legal request, one registered response pulse per accepted request.
// Optional feature macro: LSU_TIMEOUT_EN (bus watchdog of TIMEOUT cycles).
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  rsp_cause,
  output logic        mem_ready,
  input  logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state, w_next;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic [3:0]  r_cause;
  logic        r_rsp_valid, r_rsp_fault;
  logic [3:0]  r_rsp_cause;
  logic [31:0] r_rsp_rdata;

  logic        w_accept, w_done, w_tmo, w_timeout;
  logic [3:0]  w_cause;
  logic [31:0] w_st_data, w_ld_data;
  logic [3:0]  w_st_strb;

  assign w_cause  = lsu_check(req_write, req_funct3, req_addr[1:0]);
  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Lane logic runs on the latched request so bus outputs stay stable in BUS
  lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata),
    .o_wdata   (w_st_data),
    .o_wstrb   (w_st_strb),
    .o_rdata   (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // Cycles spent in BUS since entry; cleared everywhere else
  always_ff @(posedge clk) begin
    if (!resetn)                r_cnt <= '0;
    else if (r_state == ST_BUS) r_cnt <= r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state; a completion always wins over a same-cycle timeout
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = (w_cause != CAUSE_NONE) ? ST_FAULT : ST_BUS;
      end
      ST_BUS: begin
        if (mem_valid) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
          w_tmo  = 1'b1;
        end
      end
      ST_FAULT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latch and registered response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_write     <= 1'b0;
      r_cause     <= CAUSE_NONE;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_cause <= CAUSE_NONE;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
        r_write  <= req_write;
        r_cause  <= w_cause;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_fault <= 1'b0;
        r_rsp_cause <= CAUSE_NONE;
        r_rsp_rdata <= r_write ? 32'd0 : w_ld_data;
      end else if (w_tmo) begin
        r_rsp_valid <= 1'b1;
        r_rsp_fault <= 1'b1;
        r_rsp_cause <= r_write ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
        r_rsp_rdata <= '0;
      end else if (r_state == ST_FAULT) begin
        r_rsp_valid <= 1'b1;
        r_rsp_fault <= 1'b1;
        r_rsp_cause <= r_cause;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign mem_ready = (r_state == ST_BUS);
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = w_st_data;
  assign mem_wstrb = r_write ? w_st_strb : 4'b0000;
  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_fault;
  assign rsp_cause = r_rsp_cause;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, directed cases
// from the block's usage notes, then randomized requests.
module tb_load_store_unit;

  localparam int TMO       = 8;
  localparam int RAM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_cause;
  logic        mem_ready;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;

  int n_pass = 0;
  int n_tot  = 0;
  int txn    = 0;

  logic [7:0]  ref_mem [0:RAM_BYTES-1];
  logic [31:0] ram     [0:RAM_BYTES/4-1];
  logic        prev_valid = 1'b0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_cause(rsp_cause), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory block: reloads from the reference image in reset; answers one
  // cycle after seeing mem_ready; addresses beyond the RAM never answer.
  always @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      for (int w = 0; w < RAM_BYTES/4; w++)
        ram[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    end else if (mem_valid) begin
      mem_valid <= 1'b0;
    end else if (mem_ready && (mem_addr < RAM_BYTES)) begin
      mem_valid <= 1'b1;
      mem_rdata <= ram[mem_addr[9:2]];
      for (int l = 0; l < 4; l++)
        if (mem_wstrb[l]) ram[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
      txn <= txn + 1;
    end
  end

  // mem_ready must be gone in the cycle after every completion pulse
  always @(negedge clk) begin
    if (prev_valid) chk("mrdy_after_valid", {31'd0, mem_ready}, 32'd0);
    prev_valid = mem_valid;
  end

  // Reference: expected outcome of one request, applied to the byte image
  task automatic model(input bit w, input logic [2:0] f3, input int a, input logic [31:0] wd,
                       output bit fault, output logic [3:0] cause, output logic [31:0] rd,
                       output int lat, output int ntx, output logic [3:0] strb,
                       output logic [31:0] wdat);
    int size;
    bit undef;
    logic [31:0] val;
    undef = 1'b1;
    size  = 4;
    case (f3)
      3'd0: begin size = 1; undef = 1'b0; end
      3'd1: begin size = 2; undef = 1'b0; end
      3'd2: begin size = 4; undef = 1'b0; end
      3'd4: begin size = 1; undef = w; end
      3'd5: begin size = 2; undef = w; end
      default: undef = 1'b1;
    endcase
    fault = 1'b1; rd = 32'd0; lat = 2; ntx = 0; strb = 4'd0; wdat = 32'd0;
    if (undef)                 cause = w ? 4'd7 : 4'd5;
    else if ((a % size) != 0)  cause = w ? 4'd6 : 4'd4;
    else if (a >= RAM_BYTES) begin
      cause = w ? 4'd7 : 4'd5;
      lat   = TMO + 1;
    end else begin
      fault = 1'b0; cause = 4'd0; lat = 3; ntx = 1;
      if (w) begin
        strb = 4'(((1 << size) - 1) << (a % 4));
        for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % size) +: 8];
        for (int k = 0; k < size; k++) ref_mem[a+k] = wd[8*k +: 8];
      end else begin
        val = 32'd0;
        for (int k = 0; k < size; k++) val = val | (32'(ref_mem[a+k]) << (8*k));
        if (f3 == 3'd0)      rd = {{24{val[7]}},  val[7:0]};
        else if (f3 == 3'd1) rd = {{16{val[15]}}, val[15:0]};
        else                 rd = val;
      end
    end
  endtask

  // Issue one request from a negedge, check the bus beat and the response;
  // returns at the negedge of the response cycle so calls chain back-to-back.
  task automatic run_req(input bit w, input logic [2:0] f3, input int a,
                         input logic [31:0] wd, output logic [31:0] got_rd);
    bit efault; logic [3:0] ecause, estrb; logic [31:0] erd, ewd;
    int elat, entx, lat, t0;
    bit got, saw;
    model(w, f3, a, wd, efault, ecause, erd, elat, entx, estrb, ewd);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = 32'(a); req_wdata = wd;
    t0 = txn;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    lat = 0; got = 1'b0; saw = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_ready && !saw) begin
        saw = 1'b1;
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, estrb});
        if (w) chk("mem_wdata", mem_wdata, ewd);
      end
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("rsp_latency", 32'(lat), 32'(elat));
    chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, efault});
    chk("rsp_cause", {28'd0, rsp_cause}, {28'd0, ecause});
    chk("rsp_rdata", rsp_rdata, erd);
    chk("req_ready_rsp", {31'd0, req_ready}, 32'd1);
    chk("mrdy_rsp", {31'd0, mem_ready}, 32'd0);
    chk("mrdy_seen", {31'd0, saw}, (elat == 2) ? 32'd0 : 32'd1);
    chk("txn_count", 32'(txn - t0), 32'(entx));
    got_rd = rsp_rdata;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
    chk({tag, "_rsp_cause"}, {28'd0, rsp_cause}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_mem_addr"},  mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'($urandom);
    ref_mem['h100] = 8'h01; ref_mem['h101] = 8'h7F;
    ref_mem['h102] = 8'hFF; ref_mem['h103] = 8'h80;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rst");

    // Loads from word 0x80FF7F01 at 0x100
    run_req(1'b0, 3'd0, 'h102, 32'd0, r); chk("lb_102",  r, 32'hFFFFFFFF);
    run_req(1'b0, 3'd4, 'h102, 32'd0, r); chk("lbu_102", r, 32'h000000FF);
    run_req(1'b0, 3'd1, 'h102, 32'd0, r); chk("lh_102",  r, 32'hFFFF80FF);
    run_req(1'b0, 3'd2, 'h100, 32'd0, r); chk("lw_100",  r, 32'h80FF7F01);

    // Byte store into the top lane, then read back the word
    run_req(1'b1, 3'd0, 'h103, 32'h000000A5, r); chk("sb_rdata", r, 32'd0);
    run_req(1'b0, 3'd2, 'h100, 32'd0, r); chk("lw_after_sb", r, 32'hA5FF7F01);

    // Traps
    run_req(1'b0, 3'd2, 'h102, 32'd0, r);
    chk("lw_mis_cause", {28'd0, rsp_cause}, 32'd4);
    run_req(1'b1, 3'd1, 'h101, 32'h1234, r);
    chk("sh_mis_cause", {28'd0, rsp_cause}, 32'd6);
    run_req(1'b0, 3'd3, 'h100, 32'd0, r);
    run_req(1'b1, 3'd4, 'h100, 32'd0, r);
    run_req(1'b0, 3'd6, 'h101, 32'd0, r);

    // Back-to-back store then load
    run_req(1'b1, 3'd2, 'h200, 32'hDEADBEEF, r);
    run_req(1'b0, 3'd2, 'h200, 32'd0, r); chk("lw_200", r, 32'hDEADBEEF);

`ifdef LSU_TIMEOUT_EN
    run_req(1'b0, 3'd2, 'h0001F000, 32'd0, r);
    chk("tmo_cause", {28'd0, rsp_cause}, 32'd5);
    @(negedge clk);
    chk("tmo_mrdy_after", {31'd0, mem_ready}, 32'd0);
    run_req(1'b0, 3'd2, 'h100, 32'd0, r); chk("lw_after_tmo", r, 32'hA5FF7F01);
`endif

    // Randomized traffic with occasional idle gaps
    for (int n = 0; n < 60; n++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, RAM_BYTES - 1)), $urandom, r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while the bus request is up
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bus_before_rst", {31'd0, mem_ready}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("bus_rst");
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
    run_req(1'b0, 3'd5, 'h102, 32'd0, r);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
